// File: rtl/pc_unit_ras_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit_ras_if
// Brief    : Control/branch inputs and PC/RAS status outputs of pc_unit_ras.
// Revision : 1.0
// ============================================================================
interface pc_unit_ras_if #(
    parameter int ADDR_W = 64
);
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              take_branch;
    logic [1:0]        br_kind;
    logic              link;
    logic [31:0]       instruction;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] reg_target;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_target;
    logic              ras_empty;
    logic              ras_overflow;

    // Drives the PC unit (hazard unit / decode / later stages).
    modport master (
        output stall, redirect, redirect_addr, take_branch, br_kind, link,
               instruction, branch_pc, reg_target,
        input  pc, pc_plus4, branch_target, ras_empty, ras_overflow
    );

    // The PC unit itself.
    modport slave (
        input  stall, redirect, redirect_addr, take_branch, br_kind, link,
               instruction, branch_pc, reg_target,
        output pc, pc_plus4, branch_target, ras_empty, ras_overflow
    );
endinterface
`default_nettype wire

// File: rtl/pc_unit_ras.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit_ras
// Brief    : Fetch program counter with branch/redirect selection, stall
//            control and a circular return-address stack for BL/RET.
// Revision : 1.0
// ============================================================================
module pc_unit_ras #(
    parameter int                ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int                RAS_DEPTH  = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    pc_unit_ras_if.slave  bus
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] FOUR     = ADDR_W'(4);

    localparam logic [1:0] KIND_IMM26 = 2'b00;
    localparam logic [1:0] KIND_IMM19 = 2'b01;
    localparam logic [1:0] KIND_REG   = 2'b10;
    localparam logic [1:0] KIND_RET   = 2'b11;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              empty_q;
    logic              ovf_q;

    logic [ADDR_W-1:0] imm26;
    logic [ADDR_W-1:0] imm19;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] ras_top;
    logic [PTR_W-1:0]  top_ptr;
    logic              advance;
    logic              ras_full;
    logic              ras_has;
    logic              do_push;
    logic              do_pop;
    logic [ADDR_W-1:0] next_pc;
    logic              unused_instr_bits;

    // Word offsets: sign-extend the field, then scale by 4.
    assign imm26  = {{(ADDR_W-28){bus.instruction[25]}}, bus.instruction[25:0], 2'b00};
    assign imm19  = {{(ADDR_W-21){bus.instruction[23]}}, bus.instruction[23:5], 2'b00};
    assign offset = (bus.br_kind == KIND_IMM19) ? imm19 : imm26;
    assign target = bus.branch_pc + offset;
    assign seq_pc = pc_q + FOUR;

    assign ret_addr = bus.branch_pc + FOUR;
    assign top_ptr  = ptr_q - PTR_W'(1);
    assign ras_top  = ras_mem[top_ptr];
    assign ras_full = (cnt_q == FULL_CNT);
    assign ras_has  = (cnt_q != '0);

    assign unused_instr_bits = ^bus.instruction[31:26];

    assign advance = !bus.stall && !bus.redirect;
    assign do_push = advance && bus.take_branch && bus.link && (bus.br_kind == KIND_IMM26);
    assign do_pop  = advance && bus.take_branch && (bus.br_kind == KIND_RET) && ras_has;

    always_comb begin
        next_pc = seq_pc;
        if (bus.redirect) begin
            next_pc = bus.redirect_addr;
        end else if (bus.stall) begin
            next_pc = pc_q;
        end else if (bus.take_branch) begin
            case (bus.br_kind)
                KIND_IMM26,
                KIND_IMM19: next_pc = target;
                KIND_REG:   next_pc = bus.reg_target;
                default:    next_pc = ras_has ? ras_top : bus.reg_target;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_ADDR;
            ptr_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            pc_q <= next_pc;
            if (do_push) begin
                // When full, ptr_q already addresses the oldest entry.
                ras_mem[ptr_q] <= ret_addr;
                ptr_q          <= ptr_q + PTR_W'(1);
                empty_q        <= 1'b0;
                if (ras_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (do_pop) begin
                ptr_q   <= top_ptr;
                cnt_q   <= cnt_q - CNT_W'(1);
                empty_q <= (cnt_q == CNT_W'(1));
            end
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = seq_pc;
    assign bus.branch_target = target;
    assign bus.ras_empty     = empty_q;
    assign bus.ras_overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit_ras.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit_ras
// Brief    : Self-checking bench for pc_unit_ras (32-bit, reset 0x100, RAS 4).
// Revision : 1.0
// ============================================================================
module tb_pc_unit_ras;

    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_unit_ras_if #(.ADDR_W(ADDR_W)) bus ();

    pc_unit_ras #(
        .ADDR_W     (ADDR_W),
        .RESET_ADDR (32'h100),
        .RAS_DEPTH  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic        r;
        logic        st;
        logic        rd;
        logic [31:0] ra;
        logic        tk;
        logic [1:0]  kind;
        logic        lk;
        logic [31:0] ins;
        logic [31:0] bp;
        logic [31:0] rt;
        logic [31:0] epc;
        logic        eempty;
        logic        eovf;
        logic        cbt;
        logic [31:0] ebt;
    } vec_t;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        empty;
        logic        ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input string tag, input logic r, input logic st,
                                input logic rd, input logic [31:0] ra, input logic tk,
                                input logic [1:0] kind, input logic lk,
                                input logic [31:0] ins, input logic [31:0] bp,
                                input logic [31:0] rt, input logic [31:0] epc,
                                input logic eempty, input logic eovf,
                                input logic cbt, input logic [31:0] ebt);
        vec_t v;
        v.tag = tag; v.r = r; v.st = st; v.rd = rd; v.ra = ra; v.tk = tk;
        v.kind = kind; v.lk = lk; v.ins = ins; v.bp = bp; v.rt = rt;
        v.epc = epc; v.eempty = eempty; v.eovf = eovf; v.cbt = cbt; v.ebt = ebt;
        return v;
    endfunction

    task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic check1(input string tag, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected outcome, then pop and
    // compare once the edge has taken effect.
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        rst               = v.r;
        bus.stall         = v.st;
        bus.redirect      = v.rd;
        bus.redirect_addr = v.ra;
        bus.take_branch   = v.tk;
        bus.br_kind       = v.kind;
        bus.link          = v.lk;
        bus.instruction   = v.ins;
        bus.branch_pc     = v.bp;
        bus.reg_target    = v.rt;
        e.tag = v.tag; e.pc = v.epc; e.empty = v.eempty; e.ovf = v.eovf;
        sb_q.push_back(e);
        #1;
        if (v.cbt) check32({v.tag, ".branch_target"}, bus.branch_target, v.ebt);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty got 0 entries expected 1", v.tag);
        end else begin
            got = sb_q.pop_front();
            check32({got.tag, ".pc"},       bus.pc,           got.pc);
            check32({got.tag, ".pc_plus4"}, bus.pc_plus4,     got.pc + 32'd4);
            check1 ({got.tag, ".empty"},    bus.ras_empty,    got.empty);
            check1 ({got.tag, ".ovf"},      bus.ras_overflow, got.ovf);
        end
    endtask

    function automatic vec_t idle(input string tag, input logic [31:0] epc,
                                  input logic ee, input logic eo);
        return mk(tag, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, epc, ee, eo, 0, 0);
    endfunction

    initial begin
        bus.stall = 0; bus.redirect = 0; bus.redirect_addr = 0; bus.take_branch = 0;
        bus.br_kind = 0; bus.link = 0; bus.instruction = 0; bus.branch_pc = 0;
        bus.reg_target = 0;
        #2;

        //             tag        r st rd ra            tk kind  lk ins           bp            rt            epc           e  o  cbt ebt
        vecs.push_back(mk("rst0",  1, 0, 0, 0,           0, 2'b00, 0, 0,           0,            0,            32'h100,      1, 0, 0, 0));
        vecs.push_back(mk("rst1",  1, 0, 0, 0,           0, 2'b00, 0, 0,           0,            0,            32'h100,      1, 0, 0, 0));
        vecs.push_back(idle("seq0", 32'h104, 1, 0));
        vecs.push_back(idle("seq1", 32'h108, 1, 0));
        vecs.push_back(idle("seq2", 32'h10C, 1, 0));
        vecs.push_back(mk("b26",   0, 0, 0, 0,           1, 2'b00, 0, 32'h03FFFFFE, 32'h200,     0,            32'h1F8,      1, 0, 1, 32'h1F8));
        vecs.push_back(mk("b19",   0, 0, 0, 0,           1, 2'b01, 0, 32'h000000A0, 32'h200,     0,            32'h214,      1, 0, 1, 32'h214));
        vecs.push_back(mk("bl",    0, 0, 0, 0,           1, 2'b00, 1, 32'h00000040, 32'h300,     0,            32'h400,      0, 0, 1, 32'h400));
        vecs.push_back(mk("ret",   0, 0, 0, 0,           1, 2'b11, 0, 0,           0,            32'h999,      32'h304,      1, 0, 0, 0));
        vecs.push_back(mk("retmt", 0, 0, 0, 0,           1, 2'b11, 0, 0,           0,            32'h999,      32'h999,      1, 0, 0, 0));
        for (int i = 1; i <= 5; i++) begin
            vecs.push_back(mk($sformatf("bl%0d", i), 0, 0, 0, 0, 1, 2'b00, 1, 32'h40,
                              32'(i * 16), 0, 32'(i * 16 + 256), 0, (i == 5), 0, 0));
        end
        vecs.push_back(mk("pop0",  0, 0, 0, 0,           1, 2'b11, 0, 0,           0,            32'h777,      32'h54,       0, 1, 0, 0));
        vecs.push_back(mk("pop1",  0, 0, 0, 0,           1, 2'b11, 0, 0,           0,            32'h777,      32'h44,       0, 1, 0, 0));
        vecs.push_back(mk("pop2",  0, 0, 0, 0,           1, 2'b11, 0, 0,           0,            32'h777,      32'h34,       0, 1, 0, 0));
        vecs.push_back(mk("pop3",  0, 0, 0, 0,           1, 2'b11, 0, 0,           0,            32'h777,      32'h24,       1, 1, 0, 0));
        vecs.push_back(mk("pop4",  0, 0, 0, 0,           1, 2'b11, 0, 0,           0,            32'h777,      32'h777,      1, 1, 0, 0));
        vecs.push_back(mk("stlbr", 0, 1, 0, 0,           1, 2'b10, 0, 0,           0,            32'h555,      32'h777,      1, 1, 0, 0));
        vecs.push_back(mk("redir", 0, 1, 1, 32'h800,     1, 2'b00, 1, 32'h40,      32'h900,     0,            32'h800,      1, 1, 0, 0));
        vecs.push_back(mk("rdras", 0, 0, 0, 0,           1, 2'b11, 0, 0,           0,            32'hAAA,      32'hAAA,      1, 1, 0, 0));
        vecs.push_back(mk("bl6",   0, 0, 0, 0,           1, 2'b00, 1, 32'h40,      32'h1000,    0,            32'h1100,     0, 1, 0, 0));
        vecs.push_back(mk("stret", 0, 1, 0, 0,           1, 2'b11, 0, 0,           0,            32'hBBB,      32'h1100,     0, 1, 0, 0));
        vecs.push_back(mk("lk19",  0, 0, 0, 0,           1, 2'b01, 1, 32'hA0,      32'h2000,    0,            32'h2014,     0, 1, 0, 0));
        vecs.push_back(mk("ret6",  0, 0, 0, 0,           1, 2'b11, 0, 0,           0,            32'hCCC,      32'h1004,     1, 1, 0, 0));
        vecs.push_back(mk("rdtop", 0, 0, 1, 32'hFFFFFFFC, 0, 2'b00, 0, 0,           0,            0,            32'hFFFFFFFC, 1, 1, 0, 0));
        vecs.push_back(idle("wrap", 32'h0, 1, 1));
        vecs.push_back(mk("bneg",  0, 0, 0, 0,           1, 2'b01, 0, 32'h00FFFFC0, 32'h4,       0,            32'hFFFFFFFC, 1, 1, 1, 32'hFFFFFFFC));

        foreach (vecs[i]) apply(vecs[i]);

        // Reset landing on a BL with a populated stack clears everything.
        apply(mk("bl7",   0, 0, 0, 0, 1, 2'b00, 1, 32'h40, 32'h50, 0,      32'h150, 0, 1, 0, 0));
        apply(mk("rstbl", 1, 0, 0, 0, 1, 2'b00, 1, 32'h40, 32'h60, 0,      32'h100, 1, 0, 0, 0));
        apply(mk("rsret", 0, 0, 0, 0, 1, 2'b11, 0, 0,      0,      32'h321, 32'h321, 1, 0, 0, 0));

        // Back-to-back sequential fetch after a register branch.
        apply(mk("br",    0, 0, 0, 0, 1, 2'b10, 0, 0,      0,      32'h5000, 32'h5000, 1, 0, 0, 0));
        for (int i = 1; i <= 4; i++) begin
            apply(idle($sformatf("inc%0d", i), 32'h5000 + 32'(4 * i), 1, 0));
        end

        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
